// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the data-memory port and the physical memory
//   side of mem_arbiter into one interface.
//   Signal suffixes are relative to the arbiter: *_i is driven into the
//   arbiter and *_o is driven by it.
//
//   Handshake: a requester raises *_req_i and holds its request fields stable.
//   *_gnt_o marks the single cycle in which the request is accepted and
//   forwarded to memory. The requester keeps *_req_i high until its *_rvalid_o
//   pulse, which carries read data or a write acknowledge. Dropping *_req_i
//   before the grant is allowed and has no effect.
//
//   Modports:
//     slave  - the arbiter's view
//     master - the pipeline plus memory model view (testbench)
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     if_req_i;
  logic [ADDRESS_WIDTH-1:0] if_addr_i;
  logic                     if_gnt_o;
  logic                     if_rvalid_o;
  logic [DATA_WIDTH-1:0]    if_rdata_o;

  logic                     dm_req_i;
  logic                     dm_we_i;
  logic [ADDRESS_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0]    dm_wdata_i;
  logic                     dm_gnt_o;
  logic                     dm_rvalid_o;
  logic [DATA_WIDTH-1:0]    dm_rdata_o;

  logic                     stall_f_o;
  logic                     stall_m_o;

  logic                     mem_req_o;
  logic                     mem_we_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]    mem_wdata_o;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output stall_f_o, stall_m_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  stall_f_o, stall_m_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, fixed-latency memory between the fetch port
//   and the data-memory port. Only one transaction is outstanding at a time.
//   The data port wins contention.
//   A port is never eligible in its own response cycle, so the two ports
//   alternate when both keep requesting.
//
//   Ports:
//     clk_i    - clock; all state updates on the rising edge
//     rst_i    - asynchronous active-low reset
//     bus      - mem_arbiter_if.slave: fetch port, data port, stalls, memory
//     stateDbg - current FSM state (0 = IDLE, 1 = WAIT)
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus,
  output logic           stateDbg
);

  typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } stateT;
  typedef enum logic { FETCH = 1'b0, DATA = 1'b1 } ownerT;

  stateT      state;
  ownerT      owner;
  logic       ownerWe;
  logic [3:0] cnt;

  logic respCycle;
  logic ifRvalid;
  logic dmRvalid;
  logic arbitrate;
  logic ifElig;
  logic dmElig;
  logic grantIf;
  logic grantDm;
  logic memWe;

  // The response cycle doubles as an arbitration cycle. This lets the other
  // port be granted without a bubble.
  assign respCycle = (state == WAIT) && (cnt == 4'd1);
  assign ifRvalid  = respCycle && (owner == FETCH);
  assign dmRvalid  = respCycle && (owner == DATA);

  // Gating with rst_i keeps the grant and memory outputs quiet while reset
  // is held, even though the requests may already be up.
  assign arbitrate = rst_i && ((state == IDLE) || respCycle);
  assign dmElig    = bus.dm_req_i && !dmRvalid;
  assign ifElig    = bus.if_req_i && !ifRvalid;
  assign grantDm   = arbitrate && dmElig;
  assign grantIf   = arbitrate && ifElig && !dmElig;
  assign memWe     = grantDm && bus.dm_we_i;

  assign bus.if_gnt_o    = grantIf;
  assign bus.dm_gnt_o    = grantDm;
  assign bus.if_rvalid_o = ifRvalid;
  assign bus.dm_rvalid_o = dmRvalid;
  assign bus.if_rdata_o  = ifRvalid ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign bus.dm_rdata_o  = (dmRvalid && !ownerWe) ? bus.mem_rdata_i
                                                  : {DATA_WIDTH{1'b0}};

  assign bus.stall_f_o = bus.if_req_i && !ifRvalid;
  assign bus.stall_m_o = bus.dm_req_i && !dmRvalid;

  assign bus.mem_req_o   = grantDm || grantIf;
  assign bus.mem_we_o    = memWe;
  assign bus.mem_addr_o  = grantDm ? bus.dm_addr_i :
                           grantIf ? bus.if_addr_i : {ADDRESS_WIDTH{1'b0}};
  assign bus.mem_wdata_o = memWe ? bus.dm_wdata_i : {DATA_WIDTH{1'b0}};

  assign stateDbg = (state == WAIT);

  // cnt is loaded with the latency on a grant.
  // It reaches 1 in the response cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      owner   <= FETCH;
      ownerWe <= 1'b0;
    end else if (grantDm || grantIf) begin
      state   <= WAIT;
      cnt     <= 4'(MEM_LATENCY);
      owner   <= grantDm ? DATA : FETCH;
      ownerWe <= memWe;
    end else if (state == WAIT) begin
      if (cnt == 4'd1) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed checks of mem_arbiter.
//   dut uses MEM_LATENCY = 2; dut1 uses MEM_LATENCY = 1.
//   Inputs change 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic clk;
  logic rstN;
  logic stateDbg;
  logic stateDbg1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus  ();
  mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk_i    (clk),
    .rst_i    (rstN),
    .bus      (bus),
    .stateDbg (stateDbg)
  );

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rstN),
    .bus      (bus1),
    .stateDbg (stateDbg1)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleMid();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = 32'h0;
    bus.dm_wdata_i  = 32'h0;
    bus.mem_rdata_i = 32'h0;
    bus1.if_req_i    = 1'b0;
    bus1.if_addr_i   = 32'h0;
    bus1.dm_req_i    = 1'b0;
    bus1.dm_we_i     = 1'b0;
    bus1.dm_addr_i   = 32'h0;
    bus1.dm_wdata_i  = 32'h0;
    bus1.mem_rdata_i = 32'h0;
  endtask

  task automatic doReset();
    nextCycle();
    idleInputs();
    rstN = 1'b0;
    sampleMid();
    nextCycle();
    rstN = 1'b1;
    expQ.delete();
  endtask

  // Checkers.
  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: read data expected at the next rvalid, queued at grant time.
  task automatic chkPop(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = expQ.pop_front();
      chkWord(tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        eDmGnt;
    logic        eIfGnt;
    logic        eDmRv;
    logic        eIfRv;

    rstN = 1'b0;
    idleInputs();

    // Reset held with both requests up: every output quiet, stalls follow req.
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h8;
    bus.dm_req_i    = 1'b1;
    bus.dm_addr_i   = 32'h80;
    bus.dm_wdata_i  = 32'h1234;
    bus.mem_rdata_i = 32'hFFFF0000;
    sampleMid();
    chkBit("rst_if_gnt", bus.if_gnt_o, 1'b0);
    chkBit("rst_dm_gnt", bus.dm_gnt_o, 1'b0);
    chkBit("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
    chkBit("rst_dm_rvalid", bus.dm_rvalid_o, 1'b0);
    chkWord("rst_if_rdata", bus.if_rdata_o, 32'h0);
    chkWord("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    chkBit("rst_mem_req", bus.mem_req_o, 1'b0);
    chkBit("rst_mem_we", bus.mem_we_o, 1'b0);
    chkWord("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chkWord("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chkBit("rst_stall_f", bus.stall_f_o, 1'b1);
    chkBit("rst_stall_m", bus.stall_m_o, 1'b1);
    chkBit("rst_state", stateDbg, 1'b0);

    // Release: DATA wins the first cycle.
    nextCycle();
    rstN = 1'b1;
    sampleMid();
    chkBit("rel_dm_gnt", bus.dm_gnt_o, 1'b1);
    chkBit("rel_if_gnt", bus.if_gnt_o, 1'b0);
    chkWord("rel_mem_addr", bus.mem_addr_o, 32'h80);
    doReset();

    // Single fetch, latency 2.
    nextCycle();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    sampleMid();
    chkBit("sf_gnt", bus.if_gnt_o, 1'b1);
    chkBit("sf_mem_req", bus.mem_req_o, 1'b1);
    chkWord("sf_mem_addr", bus.mem_addr_o, 32'h10);
    chkBit("sf_mem_we", bus.mem_we_o, 1'b0);
    chkBit("sf_stall0", bus.stall_f_o, 1'b1);
    expQ.push_back(32'h00500093);
    nextCycle();
    sampleMid();
    chkBit("sf_gnt1", bus.if_gnt_o, 1'b0);
    chkBit("sf_mem_req1", bus.mem_req_o, 1'b0);
    chkWord("sf_mem_addr1", bus.mem_addr_o, 32'h0);
    chkBit("sf_rvalid1", bus.if_rvalid_o, 1'b0);
    chkBit("sf_stall1", bus.stall_f_o, 1'b1);
    chkBit("sf_state1", stateDbg, 1'b1);
    nextCycle();
    bus.mem_rdata_i = 32'h00500093;
    sampleMid();
    chkBit("sf_rvalid2", bus.if_rvalid_o, 1'b1);
    chkPop("sf_rdata2", bus.if_rdata_o);
    chkBit("sf_stall2", bus.stall_f_o, 1'b0);
    chkBit("sf_no_regrant", bus.if_gnt_o, 1'b0);
    nextCycle();
    bus.if_req_i    = 1'b0;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("sf_rvalid3", bus.if_rvalid_o, 1'b0);
    chkWord("sf_rdata3", bus.if_rdata_o, 32'h0);
    chkBit("sf_state3", stateDbg, 1'b0);

    // Contention: data first, fetch granted in the data response cycle.
    nextCycle();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h20;
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h200;
    sampleMid();
    chkBit("ct_dm_gnt0", bus.dm_gnt_o, 1'b1);
    chkBit("ct_if_gnt0", bus.if_gnt_o, 1'b0);
    chkWord("ct_addr0", bus.mem_addr_o, 32'h200);
    chkBit("ct_stall_f0", bus.stall_f_o, 1'b1);
    chkBit("ct_stall_m0", bus.stall_m_o, 1'b1);
    expQ.push_back(32'h11112222);
    nextCycle();
    sampleMid();
    chkBit("ct_mem_req1", bus.mem_req_o, 1'b0);
    chkBit("ct_stall_f1", bus.stall_f_o, 1'b1);
    chkBit("ct_stall_m1", bus.stall_m_o, 1'b1);
    nextCycle();
    bus.mem_rdata_i = 32'h11112222;
    sampleMid();
    chkBit("ct_dm_rvalid2", bus.dm_rvalid_o, 1'b1);
    chkPop("ct_dm_rdata2", bus.dm_rdata_o);
    chkBit("ct_if_gnt2", bus.if_gnt_o, 1'b1);
    chkBit("ct_dm_gnt2", bus.dm_gnt_o, 1'b0);
    chkWord("ct_addr2", bus.mem_addr_o, 32'h20);
    chkBit("ct_stall_m2", bus.stall_m_o, 1'b0);
    chkBit("ct_stall_f2", bus.stall_f_o, 1'b1);
    chkWord("ct_if_rdata2", bus.if_rdata_o, 32'h0);
    expQ.push_back(32'h33334444);
    nextCycle();
    bus.dm_req_i    = 1'b0;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("ct_stall_f3", bus.stall_f_o, 1'b1);
    chkBit("ct_if_rvalid3", bus.if_rvalid_o, 1'b0);
    chkBit("ct_dm_rvalid3", bus.dm_rvalid_o, 1'b0);
    nextCycle();
    bus.mem_rdata_i = 32'h33334444;
    sampleMid();
    chkBit("ct_if_rvalid4", bus.if_rvalid_o, 1'b1);
    chkPop("ct_if_rdata4", bus.if_rdata_o);
    chkBit("ct_stall_f4", bus.stall_f_o, 1'b0);
    chkWord("ct_dm_rdata4", bus.dm_rdata_o, 32'h0);
    chkBit("ct_mem_req4", bus.mem_req_o, 1'b0);
    nextCycle();
    bus.if_req_i    = 1'b0;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("ct_state5", stateDbg, 1'b0);

    // Data write: write strobe and data in the grant cycle only, zero rdata on ack.
    nextCycle();
    bus.dm_req_i    = 1'b1;
    bus.dm_we_i     = 1'b1;
    bus.dm_addr_i   = 32'h100;
    bus.dm_wdata_i  = 32'hDEADBEEF;
    bus.mem_rdata_i = 32'hAAAA5555;
    sampleMid();
    chkBit("wr_gnt0", bus.dm_gnt_o, 1'b1);
    chkBit("wr_we0", bus.mem_we_o, 1'b1);
    chkWord("wr_wdata0", bus.mem_wdata_o, 32'hDEADBEEF);
    chkWord("wr_addr0", bus.mem_addr_o, 32'h100);
    nextCycle();
    sampleMid();
    chkBit("wr_we1", bus.mem_we_o, 1'b0);
    chkWord("wr_wdata1", bus.mem_wdata_o, 32'h0);
    chkBit("wr_rvalid1", bus.dm_rvalid_o, 1'b0);
    nextCycle();
    sampleMid();
    chkBit("wr_rvalid2", bus.dm_rvalid_o, 1'b1);
    chkWord("wr_rdata2", bus.dm_rdata_o, 32'h0);
    nextCycle();
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_wdata_i  = 32'h0;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("wr_rvalid3", bus.dm_rvalid_o, 1'b0);

    // Reset during WAIT discards the in-flight response.
    nextCycle();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h40;
    sampleMid();
    chkBit("mr_gnt0", bus.if_gnt_o, 1'b1);
    nextCycle();
    rstN = 1'b0;
    sampleMid();
    chkBit("mr_state1", stateDbg, 1'b0);
    chkBit("mr_gnt1", bus.if_gnt_o, 1'b0);
    chkBit("mr_mem_req1", bus.mem_req_o, 1'b0);
    chkBit("mr_stall1", bus.stall_f_o, 1'b1);
    nextCycle();
    bus.mem_rdata_i = 32'h00000099;
    sampleMid();
    chkBit("mr_rvalid2", bus.if_rvalid_o, 1'b0);
    chkWord("mr_rdata2", bus.if_rdata_o, 32'h0);
    nextCycle();
    rstN = 1'b1;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("mr_gnt3", bus.if_gnt_o, 1'b1);
    chkWord("mr_addr3", bus.mem_addr_o, 32'h40);
    chkBit("mr_rvalid3", bus.if_rvalid_o, 1'b0);
    nextCycle();
    sampleMid();
    chkBit("mr_rvalid4", bus.if_rvalid_o, 1'b0);
    nextCycle();
    bus.mem_rdata_i = 32'hCAFE0005;
    sampleMid();
    chkBit("mr_rvalid5", bus.if_rvalid_o, 1'b1);
    chkWord("mr_rdata5", bus.if_rdata_o, 32'hCAFE0005);
    nextCycle();
    bus.if_req_i    = 1'b0;
    bus.mem_rdata_i = 32'h0;
    sampleMid();
    chkBit("mr_state6", stateDbg, 1'b0);

    // Latency 1, both ports held: DATA, FETCH, DATA, ... with no idle cycles.
    nextCycle();
    bus1.dm_req_i  = 1'b1;
    bus1.dm_addr_i = 32'h300;
    bus1.if_req_i  = 1'b1;
    bus1.if_addr_i = 32'h30;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) nextCycle();
      rd = 32'h1000 + 32'(k);
      bus1.mem_rdata_i = rd;
      sampleMid();
      eDmGnt = (k % 2 == 0);
      eIfGnt = (k % 2 == 1);
      eDmRv  = (k % 2 == 1);
      eIfRv  = (k > 0) && (k % 2 == 0);
      chkBit($sformatf("l1_dm_gnt_%0d", k), bus1.dm_gnt_o, eDmGnt);
      chkBit($sformatf("l1_if_gnt_%0d", k), bus1.if_gnt_o, eIfGnt);
      chkBit($sformatf("l1_mem_req_%0d", k), bus1.mem_req_o, 1'b1);
      chkWord($sformatf("l1_addr_%0d", k), bus1.mem_addr_o, eDmGnt ? 32'h300 : 32'h30);
      chkBit($sformatf("l1_dm_rv_%0d", k), bus1.dm_rvalid_o, eDmRv);
      chkBit($sformatf("l1_if_rv_%0d", k), bus1.if_rvalid_o, eIfRv);
      chkWord($sformatf("l1_dm_rd_%0d", k), bus1.dm_rdata_o, eDmRv ? rd : 32'h0);
      chkWord($sformatf("l1_if_rd_%0d", k), bus1.if_rdata_o, eIfRv ? rd : 32'h0);
    end
    nextCycle();
    idleInputs();
    nextCycle();

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
